// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, default sizes and width helpers for the fifo write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;
    localparam int OWNER_W       = $clog2(N_REQ_DEF);
    localparam int CNT_W         = $clog2(MAX_BURST_DEF + 1);

    // Owner index width; never narrower than one bit.
    function automatic int owner_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Beat counter must be able to hold MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin winner selection
//  Ports:
//   req_i     in  N_REQ    request vector
//   last_i    in  OWNER_W  index of the most recent owner
//   winner_o  out OWNER_W  first requester found searching last_i+1, last_i+2, ... (mod N_REQ)
//   any_o     out 1        any request present
module rr_pick #(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = 2
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [OWNER_W-1:0] last_i,
    output logic [OWNER_W-1:0] winner_o,
    output logic               any_o
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    int                 start;
    int                 offset;

    assign req_dbl = {req_i, req_i};
    assign any_o   = |req_i;

    always_comb begin
        // Rotate so the highest-priority requester lands on bit 0.
        start   = (int'(last_i) + 1) % N_REQ;
        req_rot = N_REQ'(req_dbl >> start);
        // Descending scan leaves the lowest set bit in offset.
        offset  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = i;
            end
        end
        winner_o = OWNER_W'((start + offset) % N_REQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the fifo write port
//  Ports:
//   clk_i         in   1                  fifo write clock
//   reset_i       in   1                  synchronous active-high reset
//   req_valid_i   in   N_REQ              per-requester valid
//   req_ready_o   out  N_REQ              per-requester ready, at most one high
//   req_value_i   in   N_REQ*VALUE_WIDTH  requester k in bits [k*VALUE_WIDTH +: VALUE_WIDTH]
//   fifo_valid_o  out  1                  to fifo in_valid_i
//   fifo_ready_i  in   1                  from fifo in_ready_o
//   fifo_value_o  out  VALUE_WIDTH        to fifo in_value_i
//   grant_o       out  N_REQ              one-hot owner, zero when idle
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int VALUE_WIDTH = 8,
    parameter int MAX_BURST   = MAX_BURST_DEF
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*VALUE_WIDTH-1:0] req_value_i,
    output logic                         fifo_valid_o,
    input  logic                         fifo_ready_i,
    output logic [VALUE_WIDTH-1:0]       fifo_value_o,
    output logic [N_REQ-1:0]             grant_o
);

    localparam int OWN_W  = owner_width(N_REQ);
    localparam int BCNT_W = cnt_width(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic [OWN_W-1:0]  owner_q, owner_d;
    logic [OWN_W-1:0]  last_q, last_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [OWN_W-1:0]  winner;
    logic              any_req;
    logic              in_burst;
    logic              owner_valid;
    logic              xfer;
    logic              last_beat;

    rr_pick #(
        .N_REQ   (N_REQ),
        .OWNER_W (OWN_W)
    ) u_rr_pick (
        .req_i    (req_valid_i),
        .last_i   (last_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWN_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset overrides the outputs combinationally so a beat presented on
    // the reset edge is never seen as accepted by producer or fifo.
    assign in_burst    = (state_q == BURST) && !reset_i;
    assign owner_valid = req_valid_i[owner_q];

    always_comb begin
        grant_o      = '0;
        req_ready_o  = '0;
        fifo_valid_o = 1'b0;
        fifo_value_o = '0;
        if (in_burst) begin
            grant_o[owner_q]     = 1'b1;
            req_ready_o[owner_q] = fifo_ready_i;
            fifo_valid_o         = owner_valid;
            fifo_value_o         = req_value_i[int'(owner_q)*VALUE_WIDTH +: VALUE_WIDTH];
        end
    end

    assign xfer      = fifo_valid_o & fifo_ready_i;
    assign last_beat = (cnt_q == BCNT_W'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A dropped valid ends the burst even while the fifo is full.
                if ((xfer && last_beat) || !owner_valid) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset_i;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [31:0] req_value_i;
    logic        fifo_valid_o;
    logic        fifo_ready_i;
    logic [7:0]  fifo_value_o;
    logic [3:0]  grant_o;

    fifo_wr_arbiter #(
        .N_REQ       (4),
        .VALUE_WIDTH (8),
        .MAX_BURST   (4)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_value_i  (req_value_i),
        .fifo_valid_o (fifo_valid_o),
        .fifo_ready_i (fifo_ready_i),
        .fifo_value_o (fifo_value_o),
        .grant_o      (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] pq[4][$];
    logic [3:0] en;
    logic [7:0] xq[$];
    logic [3:0] gq[$];
    logic [7:0] ex[$];
    logic [3:0] ge[$];
    logic [3:0] s_grant;
    logic [3:0] s_rdy;
    logic       s_fv;
    logic [7:0] s_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 4; k++) begin
            req_valid_i[k]         = en[k] && (pq[k].size() > 0);
            req_value_i[k*8 +: 8]  = (pq[k].size() > 0) ? pq[k][0] : 8'h00;
        end
    endtask

    // One clock: sample at negedge, model producer handshakes, drive after posedge.
    task automatic cyc();
        int         npop;
        logic [7:0] pv;
        @(negedge clk);
        s_grant = grant_o;
        s_rdy   = req_ready_o;
        s_fv    = fifo_valid_o;
        s_val   = fifo_value_o;
        gq.push_back(s_grant);
        check("ready_at_most_one", 32'($countones(s_rdy) <= 1), 32'd1);
        npop = 0;
        pv   = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (s_rdy[k] && req_valid_i[k]) begin
                npop++;
                pv = pq[k].pop_front();
            end
        end
        if (s_fv && fifo_ready_i) begin
            xq.push_back(s_val);
            check("sb_one_producer", npop, 1);
            check("sb_value", s_val, pv);
        end else begin
            check("sb_no_handshake", npop, 0);
        end
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic do_reset();
        for (int k = 0; k < 4; k++) pq[k].delete();
        en           = 4'b0000;
        fifo_ready_i = 1'b1;
        reset_i      = 1'b1;
        apply();
        cyc();
        reset_i = 1'b0;
        apply();
        xq.delete();
        gq.delete();
    endtask

    task automatic cmp_traces(input string tag);
        check({tag, "_cycles"}, gq.size(), ge.size());
        for (int i = 0; i < ge.size(); i++)
            check({tag, "_grant"}, (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF_FFFF, 32'(ge[i]));
        check({tag, "_nxfer"}, xq.size(), ex.size());
        for (int i = 0; i < ex.size(); i++)
            check({tag, "_xfer"}, (i < xq.size()) ? 32'(xq[i]) : 32'hFFFF_FFFF, 32'(ex[i]));
    endtask

    initial begin
        // 1: reset held two cycles with every requester valid
        reset_i      = 1'b1;
        fifo_ready_i = 1'b1;
        req_valid_i  = '0;
        req_value_i  = '0;
        en           = 4'b1111;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) pq[k].push_back(8'(k*32 + i));
        apply();
        repeat (2) begin
            cyc();
            check("rst_grant", s_grant, 0);
            check("rst_fifo_valid", s_fv, 0);
            check("rst_ready", s_rdy, 0);
        end
        reset_i = 1'b0;
        apply();
        xq.delete();
        gq.delete();

        // 3: all four requesting -> grants 0,1,2,3,0 of 4 beats with a bubble before each
        repeat (25) cyc();
        ge.delete();
        ex.delete();
        for (int g = 0; g < 5; g++) begin
            ge.push_back(4'b0000);
            for (int i = 0; i < 4; i++) begin
                ge.push_back(4'(1 << (g % 4)));
                ex.push_back(8'((g % 4)*32 + (g / 4)*4 + i));
            end
        end
        cmp_traces("rr4");

        // 2: single requester, burst split at MAX_BURST
        do_reset();
        for (int i = 0; i < 6; i++) pq[1].push_back(8'(8'h10 + i));
        en = 4'b0010;
        apply();
        repeat (10) cyc();
        ge = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
        ex = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        cmp_traces("single");

        // 4: fifo full for 5 cycles after 2 beats of req2
        do_reset();
        for (int i = 0; i < 4; i++) pq[2].push_back(8'(8'h40 + i));
        en = 4'b0100;
        apply();
        repeat (3) cyc();
        fifo_ready_i = 1'b0;
        apply();
        repeat (5) begin
            cyc();
            check("stall_grant", s_grant, 4'b0100);
            check("stall_ready", s_rdy, 0);
            check("stall_fifo_valid", s_fv, 1);
        end
        fifo_ready_i = 1'b1;
        apply();
        repeat (3) cyc();
        ge = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        ex = '{8'h40, 8'h41, 8'h42, 8'h43};
        cmp_traces("stall");

        // 5: req3 drops valid after 1 beat; req0 then wins by wrap-around
        do_reset();
        pq[3].push_back(8'h60);
        en = 4'b1000;
        apply();
        cyc();
        pq[0].push_back(8'h00);
        pq[0].push_back(8'h01);
        pq[2].push_back(8'h40);
        en = 4'b1101;
        apply();
        repeat (4) cyc();
        ge = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
        ex = '{8'h60, 8'h00};
        cmp_traces("early_drop");

        // 6: reset during beat 2 of req1; req0 first afterwards
        do_reset();
        for (int i = 0; i < 4; i++) pq[1].push_back(8'(8'h10 + i));
        en = 4'b0010;
        apply();
        repeat (2) cyc();
        reset_i = 1'b1;
        pq[0].push_back(8'h00);
        en = 4'b0011;
        apply();
        cyc();
        check("midrst_grant", s_grant, 0);
        check("midrst_fifo_valid", s_fv, 0);
        check("midrst_ready", s_rdy, 0);
        reset_i = 1'b0;
        apply();
        repeat (2) cyc();
        ge = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h1};
        ex = '{8'h10, 8'h00};
        cmp_traces("mid_reset");
        check("midrst_req1_head", pq[1].size() > 0 ? 32'(pq[1][0]) : 32'hFFFF_FFFF, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
